// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: five-state (IF, ID, EX, MEM, WB) control unit for the
// RV32I-subset multicycle datapath.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (0 = reset)
//   instr[31:0]  instruction word, sampled on the IF->ID edge
//   Zero         ALU zero flag, sampled on the EX->MEM edge
//   PCSrc        1 = PC+branch_offset, 0 = PC+4 (WB only)
//   ALUSrc       1 = immediate as ALU op2
//   RegWrite     register-file write enable (WB only)
//   MemToReg     1 = write back dReadData
//   loadPC       PC update enable (WB only)
//   MemRead      data-memory read strobe (MEM only)
//   MemWrite     data-memory write strobe (MEM only)
//   ALUCtrl[3:0] ALU operation
//   instr_count  retired-instruction counter (wraps)
//   illegal      sticky illegal-opcode flag
//
// Optional feature, macro CTRL_ILLEGAL_TRAP_EN: an unknown opcode parks the
// FSM in HALT after EX and sets `illegal`. Without it, unknown opcodes run
// as NOPs and `illegal` is tied to 0.
module multicycle_ctrl #(
  parameter logic [6:0] SW        = 7'b0100011,
  parameter logic [6:0] LW        = 7'b0000011,
  parameter logic [6:0] IMMEDIATE = 7'b0010011,
  parameter logic [6:0] BEQ       = 7'b1100011,
  parameter logic [6:0] RR        = 7'b0110011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic [31:0] instr_count,
  output logic        illegal
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

`ifdef CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
`endif

  state_t     state, state_nxt;
  logic [6:0] opcode_q;
  logic [2:0] funct3_q;
  logic       f7b_q;
  logic       zero_q;
  logic [3:0] alu_dec;
  logic       in_body;

  // Only opcode, funct3 and instr[30] are decoded here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic legal_op;
  logic illegal_q;
  assign legal_op = (opcode_q == SW) || (opcode_q == LW) || (opcode_q == IMMEDIATE) ||
                    (opcode_q == BEQ) || (opcode_q == RR);
  assign illegal  = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IF;
      opcode_q    <= '0;
      funct3_q    <= '0;
      f7b_q       <= 1'b0;
      zero_q      <= 1'b0;
      instr_count <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_IF) begin
        opcode_q <= instr[6:0];
        funct3_q <= instr[14:12];
        f7b_q    <= instr[30];
      end
      if (state == S_EX) zero_q <= Zero;
      if (state == S_WB) instr_count <= instr_count + 32'd1;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (state == S_EX && !legal_op) illegal_q <= 1'b1;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IF:  state_nxt = S_ID;
      S_ID:  state_nxt = S_EX;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_EX:  state_nxt = legal_op ? S_MEM : S_HALT;
      S_HALT: state_nxt = S_HALT;
`else
      S_EX:  state_nxt = S_MEM;
`endif
      S_MEM: state_nxt = S_WB;
      S_WB:  state_nxt = S_IF;
      default: state_nxt = S_IF;
    endcase
  end

  // ALU decode; IMMEDIATE shares the RR table except funct3=000 ignores f7b.
  always_comb begin
    alu_dec = ALU_ADD;
    if (opcode_q == BEQ) begin
      alu_dec = ALU_SUB;
    end else if (opcode_q == RR || opcode_q == IMMEDIATE) begin
      case (funct3_q)
        3'b000:  alu_dec = (opcode_q == RR && f7b_q) ? ALU_SUB : ALU_ADD;
        3'b111:  alu_dec = ALU_AND;
        3'b110:  alu_dec = ALU_OR;
        3'b100:  alu_dec = ALU_XOR;
        3'b010:  alu_dec = ALU_SLT;
        3'b001:  alu_dec = ALU_SLL;
        3'b101:  alu_dec = f7b_q ? ALU_SRA : ALU_SRL;
        default: alu_dec = ALU_ADD;
      endcase
    end
  end

  assign in_body = (state == S_ID) || (state == S_EX) || (state == S_MEM) || (state == S_WB);

  always_comb begin
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    loadPC   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUCtrl  = ALU_ADD;
    if (in_body) begin
      ALUCtrl  = alu_dec;
      ALUSrc   = (opcode_q == LW) || (opcode_q == SW) || (opcode_q == IMMEDIATE);
      MemToReg = (opcode_q == LW);
    end
    if (state == S_MEM) begin
      MemRead  = (opcode_q == LW);
      MemWrite = (opcode_q == SW);
    end
    if (state == S_WB) begin
      RegWrite = (opcode_q == LW) || (opcode_q == IMMEDIATE) || (opcode_q == RR);
      loadPC   = 1'b1;
      PCSrc    = (opcode_q == BEQ) && zero_q;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions from the
// test plan followed by randomized instruction streams, each cycle compared
// against a per-instruction expectation table built from the decode rules.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_RR  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        Zero = 1'b0;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite;
  logic [3:0]  ALUCtrl;
  logic [31:0] instr_count;
  logic        illegal;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] count_m = '0;

  multicycle_ctrl #(
    .SW(OP_SW), .LW(OP_LW), .IMMEDIATE(OP_IMM), .BEQ(OP_BEQ), .RR(OP_RR)
  ) dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite), .ALUCtrl(ALUCtrl),
    .instr_count(instr_count), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Observed control vector {PCSrc,ALUSrc,RegWrite,MemToReg,loadPC,MemRead,MemWrite,ALUCtrl}
  function automatic logic [31:0] obs();
    return {21'd0, PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, ALUCtrl};
  endfunction

  function automatic logic [31:0] pack(input logic pcs, als, rw, m2r, lpc, mr, mw,
                                       input logic [3:0] alu);
    return {21'd0, pcs, als, rw, m2r, lpc, mr, mw, alu};
  endfunction

  localparam logic [31:0] IDLE_VEC = {21'd0, 7'b0000000, 4'b0010};

  // Reference ALU operation from opcode/funct3/instr[30].
  function automatic logic [3:0] ref_alu(input logic [31:0] w);
    logic [3:0] tbl [8];
    logic [6:0] op;
    logic [2:0] f3;
    tbl = '{4'b0010, 4'b1001, 4'b0111, 4'b0010, 4'b1101, 4'b1000, 4'b0001, 4'b0000};
    op = w[6:0];
    f3 = w[14:12];
    if (op == OP_BEQ) return 4'b0110;
    if (op != OP_RR && op != OP_IMM) return 4'b0010;
    if (f3 == 3'd5 && w[30]) return 4'b1010;
    if (f3 == 3'd0 && w[30] && op == OP_RR) return 4'b0110;
    return tbl[f3];
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == OP_SW || op == OP_LW || op == OP_IMM || op == OP_BEQ || op == OP_RR;
  endfunction

  // Runs one instruction starting at a negedge inside IF; ends at the next IF
  // negedge. zex is Zero during EX, zmem is Zero during MEM. abort_mem pulls
  // reset during MEM after that cycle's checks.
  task automatic run_instr(input string nm, input logic [31:0] w, input logic zex,
                           input logic zmem, input bit abort_mem);
    logic [6:0] op;
    logic [3:0] alu;
    logic [31:0] exp_v;
    bit uses_imm, wb_reg;
    op = w[6:0];
    alu = ref_alu(w);
    uses_imm = (op == OP_LW || op == OP_SW || op == OP_IMM);
    wb_reg = (op == OP_LW || op == OP_IMM || op == OP_RR);
    for (int c = 1; c <= 5; c++) begin
      case (c)
        1: exp_v = IDLE_VEC;
        2, 3: exp_v = pack(0, uses_imm, 0, op == OP_LW, 0, 0, 0, alu);
        4: exp_v = pack(0, uses_imm, 0, op == OP_LW, 0, op == OP_LW, op == OP_SW, alu);
        default: exp_v = pack(op == OP_BEQ && zex, uses_imm, wb_reg, op == OP_LW, 1, 0, 0, alu);
      endcase
      check($sformatf("%s.c%0d.ctl", nm, c), obs(), exp_v);
      check($sformatf("%s.c%0d.cnt", nm, c), instr_count, count_m);
      check($sformatf("%s.c%0d.ill", nm, c), {31'd0, illegal}, 32'd0);
      instr = (c == 1) ? w : $urandom;
      Zero  = (c == 3) ? zex : (c == 4) ? zmem : 1'($urandom);
      if (c == 4 && abort_mem) begin
        rst = 1'b0;
        #1;
        check({nm, ".rst.ctl"}, obs(), IDLE_VEC);
        check({nm, ".rst.cnt"}, instr_count, 32'd0);
        count_m = '0;
        @(negedge clk);
        check({nm, ".rst.hold"}, obs(), IDLE_VEC);
        rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
    count_m = count_m + 32'd1;
  endtask

  function automatic logic [31:0] rand_instr(input bit allow_bad);
    logic [6:0] ops [5];
    logic [31:0] w;
    int unsigned k;
    ops = '{OP_SW, OP_LW, OP_IMM, OP_BEQ, OP_RR};
    w = $urandom;
    k = $urandom_range(allow_bad ? 5 : 4, 0);
    if (k < 5) w[6:0] = ops[k];
    else if (is_legal(w[6:0])) w[6:0] = 7'b1111111;
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    logic [31:0] cnt_hold;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.ctl", obs(), IDLE_VEC);
    check("reset.cnt", instr_count, 32'd0);
    check("reset.ill", {31'd0, illegal}, 32'd0);
    rst = 1'b1;

    run_instr("sw_abort", 32'h00112223, 1'b0, 1'b0, 1'b1);
    run_instr("sub",   32'h40208133, 1'b0, 1'b0, 1'b0);
    run_instr("lw",    32'h00412083, 1'b1, 1'b0, 1'b0);
    run_instr("sw",    32'h00112223, 1'b0, 1'b1, 1'b0);
    run_instr("beq_t", 32'h00208463, 1'b1, 1'b0, 1'b0);
    run_instr("beq_n", 32'h00208463, 1'b0, 1'b1, 1'b0);
    run_instr("srai",  32'h40315093, 1'b0, 1'b0, 1'b0);
    run_instr("addi30", 32'h40008093, 1'b1, 1'b1, 1'b0);
    // Mid-MEM reset with a non-zero counter must clear it.
    run_instr("lw_abort", 32'h00412083, 1'b0, 1'b0, 1'b1);
    run_instr("after_abort", 32'h40208133, 1'b0, 1'b0, 1'b0);

`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 150; i++) begin
      w = rand_instr(1'b0);
      run_instr("rnd", w, 1'($urandom), 1'($urandom), 1'b0);
    end
    // Unknown opcode: normal through EX, then parked in HALT.
    w = 32'h0000007F;
    instr = w;
    cnt_hold = count_m;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("halt.c%0d.ctl", c), obs(),
            (c == 1) ? IDLE_VEC : pack(0, 0, 0, 0, 0, 0, 0, 4'b0010));
      check($sformatf("halt.c%0d.ill", c), {31'd0, illegal}, 32'd0);
      instr = (c == 1) ? w : $urandom;
      Zero = 1'($urandom);
      @(negedge clk);
    end
    for (int c = 0; c < 20; c++) begin
      check("halt.ctl", obs(), IDLE_VEC);
      check("halt.ill", {31'd0, illegal}, 32'd1);
      check("halt.cnt", instr_count, cnt_hold);
      instr = $urandom;
      Zero = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("halt.rst.ill", {31'd0, illegal}, 32'd0);
    count_m = '0;
    @(negedge clk);
    rst = 1'b1;
    run_instr("post_halt", 32'h00412083, 1'b0, 1'b0, 1'b0);
`else
    run_instr("nop7f", 32'h0000007F, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      w = rand_instr(1'b1);
      run_instr("rnd", w, 1'($urandom), 1'($urandom), 1'b0);
    end
`endif
    check("final.cnt", instr_count, count_m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
